// File: rtl/aes_key_schedule_if.sv
// Key schedule bus: start/key capture, status flags and indexed round-key read port.
// The master drives requests; the key schedule engine is the slave.
interface aes_key_schedule_if;
    logic             start;
    logic [15:0][7:0] key_in;
    logic             busy;
    logic             done;
    logic             valid;
    logic [3:0]       rd_idx;
    logic [15:0][7:0] rd_key;

    modport master (
        output start, key_in, rd_idx,
        input  busy, done, valid, rd_key
    );

    modport slave (
        input  start, key_in, rd_idx,
        output busy, done, valid, rd_key
    );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128 forward key expansion: one round key per clock into an 11-entry
// register file, read by index for both encryption and decryption datapaths.
module aes_key_schedule #(
    parameter int NR     = 10,
    parameter bit RD_REG = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_key_schedule_if.slave   io_bus
);
    typedef logic [15:0][7:0] key_t;
    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] LAST = 4'(NR - 1);
    localparam logic [3:0] MAXI = 4'(NR);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_cnt;
    logic         r_done;
    logic         r_valid;
    key_t         r_rk [0:NR];
    key_t         w_src;
    key_t         w_next;
    key_t         w_rd;
    logic [7:0]   w_rcon;
    logic [31:0]  w_t;
    logic [3:0][31:0] w_col;
    logic [3:0][31:0] w_w;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (io_bus.start) w_state_nxt = EXPAND;
            EXPAND:  if (r_cnt == LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_rcon = 8'h00;
        unique case (r_cnt)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Columns are {row0,row1,row2,row3}; byte(r,c) lives at index 15-c-4r.
    always_comb begin
        w_src  = r_rk[r_cnt];
        w_col  = '0;
        w_w    = '0;
        w_next = '0;
        for (int c = 0; c < 4; c++) begin
            w_col[c] = {w_src[15-c], w_src[11-c], w_src[7-c], w_src[3-c]};
        end
        w_t = {SBOX[w_col[3][23:16]], SBOX[w_col[3][15:8]],
               SBOX[w_col[3][7:0]],   SBOX[w_col[3][31:24]]}
              ^ {w_rcon, 24'h0};
        w_w[0] = w_col[0] ^ w_t;
        for (int c = 1; c < 4; c++) begin
            w_w[c] = w_w[c-1] ^ w_col[c];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_next[15-c-4*r] = w_w[c][31-8*r -: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (io_bus.start) begin
                        r_rk[0] <= io_bus.key_in;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    r_rk[r_cnt + 4'd1] <= w_next;
                    r_cnt              <= r_cnt + 4'd1;
                    if (r_cnt == LAST) begin
                        r_done  <= 1'b1;
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd = '0;
        if (io_bus.rd_idx <= MAXI) w_rd = r_rk[io_bus.rd_idx];
    end

    generate
        if (RD_REG) begin : g_rd_reg
            key_t r_rd;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_rd <= '0;
                else        r_rd <= w_rd;
            end
            assign io_bus.rd_key = r_rd;
        end else begin : g_rd_comb
            assign io_bus.rd_key = w_rd;
        end
    endgenerate

    assign io_bus.busy  = (r_state == EXPAND);
    assign io_bus.done  = r_done;
    assign io_bus.valid = r_valid;
endmodule
